// File: rtl/aes_dec_pkg.sv
// -----------------------------------------------------------------------------
// aes_dec_pkg
// Shared definitions for the AES decryption datapath.
//   AES_STATE_W / AES_BYTE_W : state and byte widths
//   dec_state_e              : InvSubBytes engine FSM states
//   byte_msb()               : MSB position of byte i (byte 0 = bits [127:120])
// -----------------------------------------------------------------------------
package aes_dec_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_BYTE_W  = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } dec_state_e;

    // Byte i of the state lives at bits [byte_msb(i) -: 8].
    function automatic logic [6:0] byte_msb(input int i);
        return 7'(AES_STATE_W - 1 - AES_BYTE_W * i);
    endfunction

endpackage

// File: rtl/inv_sbox_rom.sv
// -----------------------------------------------------------------------------
// inv_sbox_rom
// 256 x 8 FIPS-197 inverse S-box with a one-cycle synchronous read, no reset.
// Ports:
//   clk  : rising-edge clock
//   addr : byte to substitute
//   data : InvSbox(addr), registered (valid one edge after addr)
// -----------------------------------------------------------------------------
module inv_sbox_rom (
    input  logic       clk,
    input  logic [7:0] addr,
    output logic [7:0] data
);

    // Listed in address order 0x00..0xff. The first element of a packed
    // concatenation lands in the highest index, so the table is read at ~addr.
    localparam logic [255:0][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic [7:0] data_d;
    logic [7:0] data_q;

    always_comb data_d = INV_SBOX[~addr];

    always_ff @(posedge clk) data_q <= data_d;

    assign data = data_q;

endmodule

// File: rtl/inv_sub_bytes.sv
// -----------------------------------------------------------------------------
// inv_sub_bytes
// InvSubBytes engine: substitutes all 16 bytes of a 128-bit state through the
// inverse S-box, LANES bytes per cycle, in 16/LANES ascending groups.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   in_valid/in_ready    : input handshake (accepted only in IDLE)
//   in_state             : state to substitute, byte 0 = [127:120]
//   out_valid/out_ready  : output handshake (result held until taken)
//   out_state            : substituted state, same byte order
//   busy                 : high while groups are being substituted
// -----------------------------------------------------------------------------
module inv_sub_bytes
    import aes_dec_pkg::*;
#(
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state,
    output logic                   busy
);

    localparam int         N        = 16 / LANES;
    localparam logic [3:0] LAST_GRP = 4'(N - 1);

    generate
        if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8 && LANES != 16) begin : g_bad_lanes
            $error("inv_sub_bytes: LANES must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    dec_state_e             state_q, state_d;
    logic [3:0]             cnt_q, cnt_d;
    logic [3:0]             wr_grp_q, wr_grp_d;   // group whose ROM data arrives this cycle
    logic                   wr_vld_q, wr_vld_d;
    logic                   en_q;                 // low until the first edge after reset
    logic [AES_STATE_W-1:0] buf_q, buf_d;
    logic [AES_STATE_W-1:0] out_q, out_d;
    logic                   accept;

    logic [LANES-1:0][AES_BYTE_W-1:0] rom_addr;
    logic [LANES-1:0][AES_BYTE_W-1:0] rom_data;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt_q == LAST_GRP) state_d = DRAIN;
            DRAIN:   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = en_q && (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == RUN) || (state_q == DRAIN);
    end

    assign accept    = in_valid && in_ready;
    assign out_state = out_q;

    // ---------------- ROM lanes ----------------
    always_comb begin
        for (int l = 0; l < LANES; l++)
            rom_addr[l] = buf_q[byte_msb(int'(cnt_q) * LANES + l) -: AES_BYTE_W];
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        inv_sbox_rom u_rom (
            .clk  (clk),
            .addr (rom_addr[l]),
            .data (rom_data[l])
        );
    end

    // ---------------- datapath ----------------
    always_comb begin
        cnt_d    = cnt_q;
        wr_grp_d = cnt_q;
        wr_vld_d = 1'b0;
        buf_d    = buf_q;
        out_d    = out_q;
        if (accept) begin
            buf_d = in_state;
            cnt_d = 4'd0;
        end
        if (state_q == RUN) begin
            wr_vld_d = 1'b1;
            cnt_d    = (cnt_q == LAST_GRP) ? 4'd0 : cnt_q + 4'd1;
        end
        // Write-back of the group issued last cycle; it never overlaps the
        // group being read this cycle, so no byte is substituted twice.
        if (wr_vld_q) begin
            for (int l = 0; l < LANES; l++)
                buf_d[byte_msb(int'(wr_grp_q) * LANES + l) -: AES_BYTE_W] = rom_data[l];
        end
        // DRAIN writes the last group; publish the completed buffer at that edge.
        if (state_q == DRAIN) out_d = buf_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= 4'd0;
            wr_grp_q <= 4'd0;
            wr_vld_q <= 1'b0;
            en_q     <= 1'b0;
            buf_q    <= '0;
            out_q    <= '0;
        end else begin
            cnt_q    <= cnt_d;
            wr_grp_q <= wr_grp_d;
            wr_vld_q <= wr_vld_d;
            en_q     <= 1'b1;
            buf_q    <= buf_d;
            out_q    <= out_d;
        end
    end

endmodule
